// File: rtl/therm_dec_pkg.sv
// Shared types and helpers for the thermometer-bar decoder: FSM states,
// popcount, and the width of the level-scaling product.
package therm_dec_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    CONFIRM,
    PUBLISH
  } decState_e;

  // Counts set bits of a code zero-extended to 32 bits; result range 0..32.
  function automatic logic [5:0] popcount(input logic [31:0] code);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(code[i]);
    end
    return n;
  endfunction

  function automatic int prodWidth(input int thermW, input int dataW);
    return dataW + $clog2(thermW + 1);
  endfunction

endpackage

// File: rtl/therm_bar_decoder_sync.sv
// Parameterised-width two-flop synchroniser for the comparator bar.
// Deliberately unreset so it maps onto plain synchroniser flops.
module therm_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] stable_q;

  always_ff @(posedge clk) begin
    meta_q   <= async_i;
    stable_q <= meta_q;
  end

  assign sync_o = stable_q;

endmodule

// File: rtl/therm_bar_decoder.sv
// Thermometer-bar decoder: synchronises the comparator bar, decodes it to a
// scaled level, debounces over FILT_LEN ticks and publishes with a strobe.
// Optional bubble detection is built when THERM_BAR_DECODER_BUBBLE_EN is defined.
module therm_bar_decoder
  import therm_dec_pkg::*;
#(
  parameter int THERM_W    = 8,
  parameter int DATA_W     = 4,
  parameter int SAMPLE_DIV = 1000,
  parameter int FILT_LEN   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [THERM_W-1:0] therm_i,
  input  logic               clr_i,
  output logic [DATA_W-1:0]  dout_o,
  output logic               dout_update_o,
  output logic               bubble_err_o
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int CNT_W  = $clog2(FILT_LEN + 1);
  localparam int LVL_W  = $clog2(THERM_W + 1);
  localparam int PROD_W = prodWidth(THERM_W, DATA_W);

  logic [THERM_W-1:0] syncCode;
  logic               tick;
  logic [LVL_W-1:0]   level;
  logic [PROD_W-1:0]  product;
  logic [DATA_W-1:0]  scaled;

  decState_e         state_q,    state_d;
  logic [DIV_W-1:0]  tickCnt_q,  tickCnt_d;
  logic [DATA_W-1:0] cand_q,     cand_d;
  logic [CNT_W-1:0]  matchCnt_q, matchCnt_d;
  logic [DATA_W-1:0] dout_q,     dout_d;
  logic              doutUpd_q,  doutUpd_d;
  logic              firstPub_q, firstPub_d;
  logic              doPublish;
  logic [CNT_W-1:0]  nextMatch;

  therm_sync #(
    .WIDTH(THERM_W)
  ) u_sync (
    .clk    (clk),
    .async_i(therm_i),
    .sync_o (syncCode)
  );

  assign tick    = (tickCnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign level   = LVL_W'(popcount(32'(syncCode)));
  assign product = PROD_W'(level) * PROD_W'({DATA_W{1'b1}});
  assign scaled  = DATA_W'(product / PROD_W'(THERM_W));

  // Outputs are registered at the completing tick so they are valid in PUBLISH.
  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tick ? '0 : tickCnt_q + DIV_W'(1);
    cand_d     = cand_q;
    matchCnt_d = matchCnt_q;
    dout_d     = dout_q;
    doutUpd_d  = 1'b0;
    firstPub_d = firstPub_q;
    doPublish  = 1'b0;
    nextMatch  = (matchCnt_q < CNT_W'(FILT_LEN)) ? matchCnt_q + CNT_W'(1) : matchCnt_q;

    case (state_q)
      EMPTY: begin
        if (tick) begin
          cand_d     = scaled;
          matchCnt_d = CNT_W'(1);
          if (FILT_LEN == 1) doPublish = 1'b1;
          else               state_d   = CONFIRM;
        end
      end
      CONFIRM: begin
        if (tick) begin
          if (scaled == cand_q) begin
            matchCnt_d = nextMatch;
            if (nextMatch == CNT_W'(FILT_LEN)) doPublish = 1'b1;
          end else begin
            cand_d     = scaled;
            matchCnt_d = CNT_W'(1);
          end
        end
      end
      PUBLISH: begin
        state_d = EMPTY;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (doPublish) begin
      state_d = PUBLISH;
      if ((scaled != dout_q) || firstPub_q) begin
        dout_d     = scaled;
        doutUpd_d  = 1'b1;
        firstPub_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      state_q    <= EMPTY;
      tickCnt_q  <= '0;
      cand_q     <= '0;
      matchCnt_q <= '0;
      dout_q     <= '0;
      doutUpd_q  <= 1'b0;
      firstPub_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      cand_q     <= cand_d;
      matchCnt_q <= matchCnt_d;
      dout_q     <= dout_d;
      doutUpd_q  <= doutUpd_d;
      firstPub_q <= firstPub_d;
    end
  end

  assign dout_o        = dout_q;
  assign dout_update_o = doutUpd_q;

`ifdef THERM_BAR_DECODER_BUBBLE_EN
  logic [THERM_W-1:0] plusOne;
  logic               bubbleSeen;
  logic               bubble_q, bubble_d;

  // A clean thermometer code plus one is a power of two, so any overlap is a bubble.
  assign plusOne    = syncCode + THERM_W'(1);
  assign bubbleSeen = |(syncCode & plusOne);

  always_comb begin
    bubble_d = bubble_q;
    if (tick && bubbleSeen) bubble_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) bubble_q <= 1'b0;
    else                 bubble_q <= bubble_d;
  end

  assign bubble_err_o = bubble_q;
`else
  assign bubble_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_therm_bar_decoder.sv
// Self-checking bench for therm_bar_decoder (THERM_W=8, DATA_W=4,
// SAMPLE_DIV=4, FILT_LEN=3); strobes are checked against a scoreboard queue.
module tb_therm_bar_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] therm;
  logic       clr;
  logic [3:0] dout;
  logic       doutUpdate;
  logic       bubbleErr;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] expQ[$];

`ifdef THERM_BAR_DECODER_BUBBLE_EN
  localparam logic BUBBLE_EXP = 1'b1;
`else
  localparam logic BUBBLE_EXP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] therm;
    logic [3:0] expDout;
    bit         expStrobe;
  } vec_t;

  vec_t vecs[10];

  therm_bar_decoder #(
    .THERM_W   (8),
    .DATA_W    (4),
    .SAMPLE_DIV(4),
    .FILT_LEN  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .therm_i      (therm),
    .clr_i        (clr),
    .dout_o       (dout),
    .dout_update_o(doutUpdate),
    .bubble_err_o (bubbleErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Hold a bar value long enough for any pending change to be confirmed and published.
  task automatic applyStimulus(input logic [7:0] value, input bit expStrobe, input logic [3:0] expDout);
    therm = value;
    if (expStrobe) expQ.push_back(expDout);
    repeat (24) @(negedge clk);
  endtask

  task automatic measureLatency(input string name, input int expEdges);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (doutUpdate) seen = 1'b1;
    end
    checkOutput({name, " latency"}, seen ? n : -1, expEdges);
    @(negedge clk);
    checkOutput({name, " strobe width"}, 32'(doutUpdate), 0);
  endtask

  // Every strobe must correspond to a queued expectation with a matching value.
  always @(negedge clk) begin
    logic [3:0] e;
    if (doutUpdate) begin
      checkOutput("strobe expected", 32'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("strobe dout", 32'(dout), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{"full bar",     8'hFF, 4'd15, 1'b1};
    vecs[1] = '{"empty bar",    8'h00, 4'd0,  1'b1};
    vecs[2] = '{"one bit",      8'h01, 4'd1,  1'b1};
    vecs[3] = '{"level 3",      8'h07, 4'd5,  1'b1};
    vecs[4] = '{"level 4",      8'h0F, 4'd7,  1'b1};
    vecs[5] = '{"level 6",      8'h3F, 4'd11, 1'b1};
    vecs[6] = '{"level 6 hold", 8'h3F, 4'd11, 1'b0};
    vecs[7] = '{"level 7",      8'h7F, 4'd13, 1'b1};
    vecs[8] = '{"level 5",      8'h1F, 4'd9,  1'b1};
    vecs[9] = '{"level 2",      8'h03, 4'd3,  1'b1};

    rst_n = 1'b0;
    clr   = 1'b0;
    therm = 8'h1F;
    repeat (5) @(negedge clk);
    checkOutput("reset dout", 32'(dout), 0);
    checkOutput("reset strobe", 32'(doutUpdate), 0);
    checkOutput("reset bubble", 32'(bubbleErr), 0);

    $display("[TB] first publish after reset");
    rst_n = 1'b1;
    expQ.push_back(4'd9);
    measureLatency("first publish", 12);
    checkOutput("first publish dout", 32'(dout), 9);
    repeat (24) @(negedge clk);
    checkOutput("steady hold dout", 32'(dout), 9);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].therm, vecs[i].expStrobe, vecs[i].expDout);
      checkOutput({vecs[i].name, " dout"}, 32'(dout), 32'(vecs[i].expDout));
      checkOutput({vecs[i].name, " bubble"}, 32'(bubbleErr), 0);
    end

    $display("[TB] alternating bar every tick");
    for (int i = 0; i < 10; i++) begin
      therm = 8'h07;
      repeat (4) @(negedge clk);
      therm = 8'h03;
      repeat (4) @(negedge clk);
    end
    checkOutput("alternate dout", 32'(dout), 3);
    applyStimulus(8'h03, 1'b0, 4'd3);
    checkOutput("alternate settle dout", 32'(dout), 3);

    $display("[TB] clear on the completing tick");
    therm = 8'h1F;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (11) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clear at tick dout", 32'(dout), 0);
    checkOutput("clear at tick strobe", 32'(doutUpdate), 0);
    expQ.push_back(4'd9);
    measureLatency("post-clear publish", 12);
    checkOutput("post-clear dout", 32'(dout), 9);

    $display("[TB] first publish of zero after clear");
    therm = 8'h00;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("cleared dout", 32'(dout), 0);
    expQ.push_back(4'd0);
    measureLatency("zero publish", 12);
    checkOutput("zero publish dout", 32'(dout), 0);

    $display("[TB] bubbled code");
    applyStimulus(8'h0B, 1'b1, 4'd5);
    checkOutput("bubble dout", 32'(dout), 5);
    checkOutput("bubble flag", 32'(bubbleErr), 32'(BUBBLE_EXP));
    applyStimulus(8'h07, 1'b0, 4'd5);
    checkOutput("bubble recover dout", 32'(dout), 5);
    checkOutput("bubble sticky", 32'(bubbleErr), 32'(BUBBLE_EXP));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("bubble after reset", 32'(bubbleErr), 0);
    checkOutput("dout after reset", 32'(dout), 0);
    rst_n = 1'b1;

    repeat (5) @(negedge clk);
    checkOutput("outstanding expectations", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/therm_bar_decoder.md
# therm_bar_decoder

Front-end decoder for the multimeter's comparator-ladder input. It samples an asynchronous thermometer-coded bar, which is the same shape as the LED bar the display side drives, from a bank of THERM_W comparators, and synchronises and debounces it. It converts the bar to a scaled binary level and publishes that level with a one-cycle update strobe. It is the producer end of the din/din_update interface that the LED-bar driver consumes.

## Interface
- THERM_W, 8, number of comparator (bar) inputs; 2..32
- DATA_W, 4, output data width
- SAMPLE_DIV, 1000, clock cycles between sample ticks; ≥2
- FILT_LEN, 4, consecutive identical decoded samples required before publishing; ≥1
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- therm_i  in  THERM_W  asynchronous comparator outputs; bit 0 is the lowest threshold
- clr_i  in  1  synchronous clear, same effect as reset
- dout_o  out  DATA_W  published scaled level
- dout_update_o  out  1  one-cycle strobe when dout_o takes a new value
- bubble_err_o  out  1  sticky flag: a non-thermometer code was sampled

## Operation
- therm_i passes through a 2-FF synchroniser. The synchroniser registers are not reset.
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. A tick is asserted in the cycle where count == SAMPLE_DIV-1.
- Decode on tick:
  - level = popcount of the synchronised code, range 0..THERM_W.
  - scaled = (level * (2^DATA_W - 1)) / THERM_W, with integer truncation.
  - The intermediate width is DATA_W + clog2(THERM_W+1) bits, so the product cannot overflow.
- States:
  - EMPTY: no candidate held.
  - CONFIRM: a candidate is held with match_cnt between 1 and FILT_LEN-1.
  - PUBLISH: a single cycle that drives the output.
- Transitions, evaluated on tick:
  - EMPTY → candidate = scaled, match_cnt = 1. Go to CONFIRM, or directly to PUBLISH if FILT_LEN = 1.
  - CONFIRM with scaled == candidate → match_cnt + 1. On reaching FILT_LEN, go to PUBLISH.
  - CONFIRM with scaled != candidate → candidate = scaled, match_cnt = 1. Stay in CONFIRM.
  - PUBLISH → on the next cycle, return to EMPTY.
- In PUBLISH:
  - If candidate != dout_o, or first_pub is set, load dout_o = candidate and pulse dout_update_o.
  - Otherwise no strobe is issued.
  - first_pub is set by reset or clear and cleared on the first publish.
- Boundaries:
  - All-zero bar gives 0. All-one bar gives 2^DATA_W - 1.
  - match_cnt saturates; it never wraps.
  - A tick cannot land in a PUBLISH cycle because SAMPLE_DIV ≥ 2.

## Timing
- Reset or clear values:
  - dout_o = 0, dout_update_o = 0, bubble_err_o = 0.
  - Tick counter = 0, state = EMPTY, first_pub = 1.
- Priority:
  - ~rst_n or clr_i overrides everything, including a simultaneous tick or PUBLISH.
  - Reset or clear in the middle of confirmation discards the candidate.
- A therm_i change is visible to the decoder 2 cycles later.
- Publish latency: dout_o and dout_update_o become valid 1 cycle after the tick that completes FILT_LEN matches.
- From the first tick after reset to the first strobe: (FILT_LEN-1)*SAMPLE_DIV + 1 cycles for a steady input.
- dout_update_o is high for exactly 1 cycle.
- dout_o holds between strobes.

## Configuration
- THERM_BAR_DECODER_BUBBLE_EN defined:
  - On each tick, a sampled code with any 0 bit below a 1 bit sets bubble_err_o.
  - bubble_err_o stays set until reset or clear.
  - The level is still popcount, so the decode tolerates bubbles.
- Not defined:
  - No detection logic is built.
  - bubble_err_o is tied to 0.

## Structure
- Package therm_dec_pkg holds:
  - The state enum (EMPTY, CONFIRM, PUBLISH).
  - A popcount function.
  - A function giving the intermediate width for the scaling product.
- Sub-module therm_sync: parameterised-width 2-FF synchroniser.

## Test plan
All scenarios use THERM_W=8, DATA_W=4, SAMPLE_DIV=4, FILT_LEN=3.
- Reset, then hold therm_i=8'h1F (level 5) → one strobe with dout_o=9. The strobe falls 1 cycle after the 3rd tick. No further strobes while the input holds.
- Step therm_i 8'h1F → 8'hFF → strobe with dout_o=15 after 3 matching ticks. Step to 8'h00 → strobe with dout_o=0.
- Alternate therm_i between 8'h03 and 8'h07 on every tick → no strobe, dout_o unchanged.
- Apply 8'h1F and assert clr_i on the cycle the 3rd tick occurs → no strobe and dout_o=0. A strobe with dout_o=9 follows 3 ticks later because first_pub is set.
- Apply therm_i=8'h0B with the macro defined → bubble_err_o=1, and it stays 1 after the input returns to 8'h07. dout_o=5 (level 3 → 45/8). The flag clears on rst_n=0.
- Apply 8'h0B with the macro undefined → bubble_err_o stays 0 and dout_o=5.
